// File: rtl/register_read_control_pkg.sv
// Shared constants for the operand-fetch controller: stage code,
// RISC-V opcodes and the read-control FSM state encoding.
package register_read_control_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_REGISTER_READ = 3'd2;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        RRC_IDLE  = 2'd0,
        RRC_WAIT1 = 2'd1,
        RRC_WAIT2 = 2'd2,
        RRC_DONE  = 2'd3
    } rrc_state_t;

endpackage

// File: rtl/register_read_control_operand_usage_decoder.sv
// Combinational opcode decode: which source registers an instruction reads.
// Ports: i_opcode (7) in; o_needs_rs1, o_needs_rs2 out.
module operand_usage_decoder
    import register_read_control_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_needs_rs1,
    output logic       o_needs_rs2
);

    always_comb begin
        o_needs_rs1 = 1'b0;
        o_needs_rs2 = 1'b0;
        case (i_opcode)
            OPC_OP: begin
                o_needs_rs1 = 1'b1;
                o_needs_rs2 = 1'b1;
            end
            OPC_STORE,
            OPC_BRANCH: begin
                o_needs_rs1 = 1'b1;
                o_needs_rs2 = 1'b1;
            end
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR: begin
                o_needs_rs1 = 1'b1;
            end
            default: begin
                o_needs_rs1 = 1'b0;
                o_needs_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/register_read_control.sv
// Operand-fetch controller: sequences rs1/rs2 reads through the single
// synchronous register-file read port and latches them for execute.
// Ports: i_clk, i_reset (sync, active-high), i_stage, i_opcode, i_rs1,
//   i_rs2, i_rf_read_data in; o_rf_read_addr, o_rs1_value, o_rs2_value,
//   o_read_done out.
// Optional macro REG_READ_SKIP_EN: skip unneeded and x0 reads (forced 0).
module register_read_control
    import register_read_control_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [STAGE_WIDTH-1:0] i_stage,
    input  logic [6:0]             i_opcode,
    input  logic [4:0]             i_rs1,
    input  logic [4:0]             i_rs2,
    input  logic [31:0]            i_rf_read_data,
    output logic [4:0]             o_rf_read_addr,
    output logic [31:0]            o_rs1_value,
    output logic [31:0]            o_rs2_value,
    output logic                   o_read_done
);

    rrc_state_t  r_state;
    logic [31:0] r_rs1_value;
    logic [31:0] r_rs2_value;
    logic        r_read_done;

    logic        w_needs_rs1;
    logic        w_needs_rs2;
    logic        w_eff_rs1;
    logic        w_eff_rs2;
    logic        w_in_stage;
    logic [4:0]  w_rf_read_addr;

    operand_usage_decoder u_usage (
        .i_opcode    (i_opcode),
        .o_needs_rs1 (w_needs_rs1),
        .o_needs_rs2 (w_needs_rs2)
    );

`ifdef REG_READ_SKIP_EN
    assign w_eff_rs1 = w_needs_rs1 && (i_rs1 != 5'd0);
    assign w_eff_rs2 = w_needs_rs2 && (i_rs2 != 5'd0);
`else
    // Fixed-latency build: every read goes to the register file.
    logic w_unused_needs;
    assign w_unused_needs = w_needs_rs1 ^ w_needs_rs2;
    assign w_eff_rs1 = 1'b1;
    assign w_eff_rs2 = 1'b1;
`endif

    assign w_in_stage = (i_stage == STAGE_REGISTER_READ);

    // Address leads the data by one cycle: the read for a WAITn state
    // is presented in the state before it.
    always_comb begin
        w_rf_read_addr = 5'd0;
        case (r_state)
            RRC_IDLE: begin
                if (w_eff_rs1)
                    w_rf_read_addr = i_rs1;
                else if (w_eff_rs2)
                    w_rf_read_addr = i_rs2;
            end
            RRC_WAIT1: w_rf_read_addr = i_rs2;
            default:   w_rf_read_addr = 5'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= RRC_IDLE;
            r_rs1_value <= 32'd0;
            r_rs2_value <= 32'd0;
            r_read_done <= 1'b0;
        end else begin
            case (r_state)
                RRC_IDLE: begin
                    if (w_in_stage) begin
                        if (!w_eff_rs1)
                            r_rs1_value <= 32'd0;
                        if (!w_eff_rs2)
                            r_rs2_value <= 32'd0;
                        if (w_eff_rs1) begin
                            r_state <= RRC_WAIT1;
                        end else if (w_eff_rs2) begin
                            r_state <= RRC_WAIT2;
                        end else begin
                            r_state     <= RRC_DONE;
                            r_read_done <= 1'b1;
                        end
                    end
                end
                RRC_WAIT1: begin
                    // Leaving the stage mid-fetch drops the in-flight data.
                    if (!w_in_stage) begin
                        r_state <= RRC_IDLE;
                    end else begin
                        r_rs1_value <= i_rf_read_data;
                        if (w_eff_rs2) begin
                            r_state <= RRC_WAIT2;
                        end else begin
                            r_state     <= RRC_DONE;
                            r_read_done <= 1'b1;
                        end
                    end
                end
                RRC_WAIT2: begin
                    if (!w_in_stage) begin
                        r_state <= RRC_IDLE;
                    end else begin
                        r_rs2_value <= i_rf_read_data;
                        r_state     <= RRC_DONE;
                        r_read_done <= 1'b1;
                    end
                end
                RRC_DONE: begin
                    if (!w_in_stage) begin
                        r_state     <= RRC_IDLE;
                        r_read_done <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= RRC_IDLE;
                    r_read_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_rf_read_addr = w_rf_read_addr;
    assign o_rs1_value    = r_rs1_value;
    assign o_rs2_value    = r_rs2_value;
    assign o_read_done    = r_read_done;

endmodule

// File: tb/tb_register_read_control.sv
// Randomized self-checking bench for register_read_control with a
// behavioural register file and an operand-usage reference model.
module tb_register_read_control;
    import register_read_control_pkg::*;

`ifdef REG_READ_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic [STAGE_WIDTH-1:0] stage;
    logic [6:0]             opcode;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [31:0]            rf_read_data;
    logic [4:0]             rf_read_addr;
    logic [31:0]            rs1_value;
    logic [31:0]            rs2_value;
    logic                   read_done;

    logic [31:0] rf [32];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last1 = 32'd0;
    logic [31:0] last2 = 32'd0;

    localparam logic [STAGE_WIDTH-1:0] STAGE_OTHER = 3'd3;

    always #5 clk = ~clk;

    // Synchronous single-port register file model.
    always @(posedge clk) rf_read_data <= rf[rf_read_addr];

    register_read_control dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_stage        (stage),
        .i_opcode       (opcode),
        .i_rs1          (rs1),
        .i_rs2          (rs2),
        .i_rf_read_data (rf_read_data),
        .o_rf_read_addr (rf_read_addr),
        .o_rs1_value    (rs1_value),
        .o_rs2_value    (rs2_value),
        .o_read_done    (read_done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit uses1(input logic [6:0] op);
        return op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD,
                          OPC_STORE, OPC_BRANCH, OPC_JALR};
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic bit eff(input bit used, input logic [4:0] idx);
        return SKIP ? (used && idx != 5'd0) : 1'b1;
    endfunction

    task automatic run_op(input logic [6:0] op, input logic [4:0] a,
                          input logic [4:0] b, input int hold);
        bit          e1, e2;
        int          lat, seen;
        logic [31:0] x1, x2;
        logic [4:0]  addr0;
        e1 = eff(uses1(op), a);
        e2 = eff(uses2(op), b);
        lat = 1 + int'(e1) + int'(e2);
        x1 = e1 ? rf[a] : 32'd0;
        x2 = e2 ? rf[b] : 32'd0;
        addr0 = e1 ? a : (e2 ? b : 5'd0);
        @(posedge clk);
        #1;
        stage = STAGE_REGISTER_READ;
        opcode = op;
        rs1 = a;
        rs2 = b;
        @(negedge clk);
        check("addr_T", rf_read_addr, addr0);
        check("done_T", read_done, 0);
        seen = 0;
        for (int c = 1; c <= 5 && seen == 0; c++) begin
            @(negedge clk);
            if (c == 1)
                check("addr_T1", rf_read_addr, e1 ? b : 5'd0);
            if (read_done)
                seen = c;
        end
        check("latency", seen, lat);
        check("rs1_value", rs1_value, x1);
        check("rs2_value", rs2_value, x2);
        last1 = x1;
        last2 = x2;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("done_hold", read_done, 1);
        end
        @(posedge clk);
        #1;
        stage = STAGE_OTHER;
        @(negedge clk);
        check("done_exit", read_done, 1);
        @(negedge clk);
        check("done_clear", read_done, 0);
        check("rs1_kept", rs1_value, x1);
        check("rs2_kept", rs2_value, x2);
    endtask

    task automatic abort_op(input logic [4:0] a, input logic [4:0] b);
        @(posedge clk);
        #1;
        stage = STAGE_REGISTER_READ;
        opcode = OPC_BRANCH;
        rs1 = a;
        rs2 = b;
        @(posedge clk);
        #1;
        stage = STAGE_OTHER;
        @(negedge clk);
        check("abort_addr_w1", rf_read_addr, b);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_done", read_done, 0);
        end
        check("abort_rs1", rs1_value, last1);
        check("abort_rs2", rs2_value, last2);
    endtask

    task automatic reset_op(input logic [4:0] a, input logic [4:0] b);
        @(posedge clk);
        #1;
        stage = STAGE_REGISTER_READ;
        opcode = OPC_BRANCH;
        rs1 = a;
        rs2 = b;
        @(posedge clk);
        #1;
        reset = 1'b1;
        stage = STAGE_OTHER;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_rs1", rs1_value, 0);
        check("rst_rs2", rs2_value, 0);
        check("rst_done", read_done, 0);
        check("rst_addr_idle", rf_read_addr, a);
        last1 = 32'd0;
        last2 = 32'd0;
    endtask

    logic [6:0] ops [9];

    initial begin
        ops = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_JAL};
        for (int i = 0; i < 32; i++)
            rf[i] = $urandom;
        reset = 1'b1;
        stage = STAGE_OTHER;
        opcode = 7'd0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rs1", rs1_value, 0);
        check("reset_rs2", rs2_value, 0);
        check("reset_done", read_done, 0);
        check("reset_addr", rf_read_addr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        rf[5] = 32'h11;
        rf[6] = 32'h22;
        run_op(OPC_OP, 5'd5, 5'd6, 1);
        rf[7] = 32'hDEAD;
        run_op(OPC_OP_IMM, 5'd7, 5'd3, 0);
        run_op(OPC_LUI, 5'd1, 5'd2, 0);
        rf[9] = 32'h55;
        run_op(OPC_STORE, 5'd0, 5'd9, 2);
        reset_op(5'd3, 5'd4);
        run_op(OPC_BRANCH, 5'd3, 5'd4, 0);
        run_op(OPC_JAL, 5'd4, 5'd8, 1);
        abort_op(5'd10, 5'd11);
        run_op(OPC_LOAD, 5'd12, 5'd0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            logic [4:0] a, b;
            if ($urandom_range(0, 7) == 0)
                op = 7'($urandom);
            else
                op = ops[$urandom_range(0, 8)];
            a = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            rf[a] = $urandom;
            rf[b] = $urandom;
            if ($urandom_range(0, 9) == 0)
                abort_op(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
            run_op(op, a, b, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
